// File: rtl/reaction_fsm.sv
// Reaction-time game controller.
// A start press arms a pseudo-random delay; when it expires the game enters GO
// and counts milliseconds until the react press, keeping the best time seen.
// Pressing react too early is a false start; no press for 8191 ms is a timeout.
module reaction_fsm #(
   parameter int TICKS_PER_MS = 100000,
   parameter int MIN_DELAY_MS = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_start,
   input  logic        btn_react,
   output logic [12:0] number,
   output logic [1:0]  mode,
   output logic        select
);

   localparam int            PW         = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_MS - 1);
   localparam logic [12:0]   MS_MAX     = 13'h1FFF;
   localparam logic [12:0]   MS_PRE_MAX = 13'h1FFE;
   localparam logic [15:0]   LFSR_SEED  = 16'hACE1;
   // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
   localparam logic [15:0]   LFSR_TAPS  = 16'hB400;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_GO,
      S_RESULT,
      S_FALSE
   } state_t;

   state_t        state_q;
   logic          start_q;
   logic          react_q;
   logic [PW-1:0] presc_q;
   logic [15:0]   lfsr_q;
   logic [15:0]   lfsr_d;
   logic [11:0]   delay_q;
   logic [11:0]   delay_d;
   logic [12:0]   elapsed_q;
   logic [12:0]   last_q;
   logic [12:0]   best_q;
   logic [12:0]   number_q;
   logic [1:0]    mode_q;
   logic          select_q;

   logic          start_edge;
   logic          react_edge;
   logic          tick;

   // A press is an event only on the cycle the level first rises
   assign start_edge = btn_start & ~start_q;
   assign react_edge = btn_react & ~react_q;
   assign tick       = (presc_q == PRESC_MAX);

   // The all-zero state is unreachable from a non-zero seed
   assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
   // Random wait length sampled at the moment WAIT is entered
   assign delay_d = 12'(MIN_DELAY_MS) + {1'b0, lfsr_q[10:0]};

   assign number = number_q;
   assign mode   = mode_q;
   assign select = select_q;

   // Game state machine with button history, ms prescaler, LFSR and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         start_q   <= 1'b0;
         react_q   <= 1'b0;
         presc_q   <= '0;
         lfsr_q    <= LFSR_SEED;
         delay_q   <= '0;
         elapsed_q <= '0;
         last_q    <= '0;
         best_q    <= MS_MAX;
         number_q  <= MS_MAX;
         mode_q    <= 2'b00;
         select_q  <= 1'b0;
      end else begin
         start_q <= btn_start;
         react_q <= btn_react;
         lfsr_q  <= lfsr_d;
         // Free-running prescaler; any state change below restarts it from zero
         presc_q <= tick ? '0 : presc_q + PW'(1);

         case (state_q)
            S_IDLE, S_RESULT, S_FALSE: begin
               // react is ignored here; only start begins a new round
               if (start_edge) begin
                  state_q  <= S_WAIT;
                  delay_q  <= delay_d;
                  presc_q  <= '0;
                  mode_q   <= 2'b01;
                  number_q <= '0;
                  select_q <= 1'b0;
               end
            end

            S_WAIT: begin
               // react wins over the final tick, so an early press is always a false start
               if (react_edge) begin
                  state_q  <= S_FALSE;
                  presc_q  <= '0;
                  mode_q   <= 2'b11;
                  number_q <= '0;
                  select_q <= 1'b1;
               end else if (tick) begin
                  if (delay_q <= 12'd1) begin
                     state_q   <= S_GO;
                     delay_q   <= '0;
                     elapsed_q <= '0;
                     presc_q   <= '0;
                     mode_q    <= 2'b10;
                     number_q  <= '0;
                     select_q  <= 1'b0;
                  end else begin
                     delay_q <= delay_q - 12'd1;
                  end
               end
            end

            S_GO: begin
               // A press on a tick cycle latches the count before that tick is applied
               if (react_edge) begin
                  state_q  <= S_RESULT;
                  presc_q  <= '0;
                  last_q   <= elapsed_q;
                  mode_q   <= 2'b11;
                  number_q <= elapsed_q;
                  select_q <= 1'b0;
                  if (elapsed_q < best_q) begin
                     best_q <= elapsed_q;
                  end
               end else if (tick) begin
                  if (elapsed_q >= MS_PRE_MAX) begin
                     // Timeout: saturate and report, leaving best untouched
                     state_q   <= S_RESULT;
                     presc_q   <= '0;
                     elapsed_q <= MS_MAX;
                     last_q    <= MS_MAX;
                     mode_q    <= 2'b11;
                     number_q  <= MS_MAX;
                     select_q  <= 1'b1;
                  end else begin
                     elapsed_q <= elapsed_q + 13'd1;
                     number_q  <= elapsed_q + 13'd1;
                  end
               end
            end

            default: begin
               state_q  <= S_IDLE;
               presc_q  <= '0;
               mode_q   <= 2'b00;
               number_q <= best_q;
               select_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_fsm.sv
// Bench for reaction_fsm: fixed vector table, directed multi-cycle rounds and
// random button activity compared every cycle against a millisecond-level model.
module tb_reaction_fsm;

   localparam int T      = 4;
   localparam int MIN_MS = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_start = 1'b0;
   logic        btn_react = 1'b0;
   logic [12:0] number;
   logic [1:0]  mode;
   logic        select;

   int n_checks = 0;
   int n_errors = 0;

   reaction_fsm #(.TICKS_PER_MS(T), .MIN_DELAY_MS(MIN_MS)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_react (btn_react),
      .number    (number),
      .mode      (mode),
      .select    (select)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Phases: 0 idle, 1 waiting, 2 go, 3 result, 4 false start.
   // Time in a phase is kept as cycles since entry; ms follow by division.
   int          m_ph    = 0;
   int          m_cyc   = 0;
   int          m_delay = 0;
   int          m_last  = 0;
   int          m_best  = 8191;
   bit          m_tmo   = 1'b0;
   bit          m_ps    = 1'b0;
   bit          m_pr    = 1'b0;
   logic [15:0] m_lfsr  = 16'hACE1;

   always @(posedge clk) begin
      bit se;
      bit re;
      int nxt;
      if (rst) begin
         m_ph = 0; m_cyc = 0; m_delay = 0; m_last = 0; m_best = 8191;
         m_tmo = 1'b0; m_ps = 1'b0; m_pr = 1'b0; m_lfsr = 16'hACE1;
      end else begin
         se = btn_start && !m_ps;
         re = btn_react && !m_pr;
         m_ps = btn_start;
         m_pr = btn_react;
         nxt = m_ph;
         case (m_ph)
            1: begin
               if (re) nxt = 4;
               else if (m_cyc + 1 == m_delay * T) nxt = 2;
            end
            2: begin
               if (re) begin
                  nxt = 3; m_last = m_cyc / T; m_tmo = 1'b0;
                  if (m_last < m_best) m_best = m_last;
               end else if (m_cyc + 1 == 8191 * T) begin
                  nxt = 3; m_last = 8191; m_tmo = 1'b1;
               end
            end
            default: begin
               if (se) begin
                  nxt = 1;
                  m_delay = MIN_MS + int'(m_lfsr[10:0]);
               end
            end
         endcase
         m_cyc = (nxt != m_ph) ? 0 : m_cyc + 1;
         m_ph = nxt;
         if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
         else           m_lfsr = m_lfsr >> 1;
      end
   end

   function automatic int m_number();
      case (m_ph)
         0:       return m_best;
         2:       return m_cyc / T;
         3:       return m_last;
         default: return 0;
      endcase
   endfunction

   function automatic int m_mode();
      return (m_ph >= 3) ? 3 : m_ph;
   endfunction

   function automatic int m_select();
      if (m_ph == 4) return 1;
      if (m_ph == 3) return int'(m_tmo);
      return 0;
   endfunction

   always @(negedge clk) begin
      chk("model_number", int'(number), m_number());
      chk("model_mode",   int'(mode),   m_mode());
      chk("model_select", int'(select), m_select());
      chk("model_best",   int'(dut.best_q), m_best);
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Poll until the DUT shows the wanted mode (and number, unless negative)
   task automatic wait_for(input string name, input int md, input int num, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (int'(mode) == md && (num < 0 || int'(number) == num)) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      chk(name, int'(ok), 1);
   endtask

   typedef struct {
      bit r;
      bit s;
      bit a;
      int num;
      int md;
      int sel;
   } vec_t;

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{1, 0, 0, 8191, 0, 0};
      vecs[1]  = '{1, 0, 0, 8191, 0, 0};
      vecs[2]  = '{0, 0, 0, 8191, 0, 0};
      vecs[3]  = '{0, 0, 1, 8191, 0, 0};  // react in idle ignored
      vecs[4]  = '{0, 0, 0, 8191, 0, 0};
      vecs[5]  = '{0, 1, 0, 0, 1, 0};     // start -> wait
      vecs[6]  = '{0, 1, 0, 0, 1, 0};     // held start, no new event
      vecs[7]  = '{0, 0, 0, 0, 1, 0};
      vecs[8]  = '{0, 1, 1, 0, 3, 1};     // start+react together: react wins
      vecs[9]  = '{0, 1, 1, 0, 3, 1};
      vecs[10] = '{0, 0, 1, 0, 3, 1};
      vecs[11] = '{0, 1, 1, 0, 1, 0};     // new round; react still held
      vecs[12] = '{0, 0, 1, 0, 1, 0};     // held react is not a press
      vecs[13] = '{0, 0, 0, 0, 1, 0};
      vecs[14] = '{0, 0, 1, 0, 3, 1};     // fresh react press -> false start
      vecs[15] = '{1, 0, 0, 8191, 0, 0};

      for (int i = 0; i < 16; i++) begin
         rst = vecs[i].r;
         btn_start = vecs[i].s;
         btn_react = vecs[i].a;
         step();
         chk($sformatf("vec%0d_number", i), int'(number), vecs[i].num);
         chk($sformatf("vec%0d_mode", i),   int'(mode),   vecs[i].md);
         chk($sformatf("vec%0d_select", i), int'(select), vecs[i].sel);
      end

      // Normal round, react 5 ms into GO
      rst = 1'b1; btn_start = 1'b0; btn_react = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      btn_start = 1'b1;
      step();
      chk("r1_mode_wait", int'(mode), 1);
      btn_start = 1'b0;
      wait_for("r1_reach_go5", 2, 5, 15000);
      btn_react = 1'b1;
      step();
      chk("r1_number", int'(number), 5);
      chk("r1_mode",   int'(mode),   3);
      chk("r1_select", int'(select), 0);
      chk("r1_best",   int'(dut.best_q), 5);
      btn_react = 1'b0;
      step();

      // React on the very cycle of the tick that would make 8
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      wait_for("r2_reach_go7", 2, 7, 15000);
      step(); step(); step();
      btn_react = 1'b1;
      step();
      chk("r2_number_pre_inc", int'(number), 7);
      chk("r2_mode",   int'(mode),   3);
      chk("r2_select", int'(select), 0);
      chk("r2_best_kept", int'(dut.best_q), 5);
      btn_react = 1'b0;
      step();

      // False start
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      step();
      btn_react = 1'b1;
      step();
      chk("fs_number", int'(number), 0);
      chk("fs_mode",   int'(mode),   3);
      chk("fs_select", int'(select), 1);
      chk("fs_best",   int'(dut.best_q), 5);
      btn_react = 1'b0;
      step();

      // Reset in the middle of GO
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      wait_for("rg_reach_go3", 2, 3, 15000);
      rst = 1'b1;
      step();
      chk("rg_number", int'(number), 8191);
      chk("rg_mode",   int'(mode),   0);
      chk("rg_select", int'(select), 0);
      chk("rg_best",   int'(dut.best_q), 8191);
      rst = 1'b0;
      step();

      // Timeout with no react press
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      wait_for("to_reach_result", 3, -1, 45000);
      chk("to_number", int'(number), 8191);
      chk("to_select", int'(select), 1);
      chk("to_best",   int'(dut.best_q), 8191);

      // Random button activity against the model
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) btn_start = ~btn_start;
         if ($urandom_range(0, 5) == 0) btn_react = ~btn_react;
         rst = ($urandom_range(0, 999) == 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
